lsu_req_ctrl: RTL and testbench
===============================

# lsu_req_ctrl

Parametrised load/store request controller between the EXE stage and the DCache request/response port. It is the successor to the single-outstanding EXE-stage DCache interface. It formats store data and byte strobes for all MIPS store types and detects AdEL/AdES. It keeps up to MAX_OUTSTANDING requests in flight and discards responses of requests killed by a pipeline flush. Returned load data is aligned, extended or merged (LWL/LWR) before it reaches MEM/WB.

## Interface
- MAX_OUTSTANDING, 2, in-flight requests tracked, 1..8
- TAG_W, 20, cache tag width
- INDEX_W, 8, cache index width
- OFFSET_W, 4, cache offset width; TAG_W+INDEX_W+OFFSET_W = 32
- clk  in  1  clock; reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE holds a memory instruction
- req_ready  out  1  request consumed this cycle
- req_type  in  4  lsu_pkg encoding: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR
- req_addr  in  32  effective address
- req_rt  in  32  rt value: store data, or merge base for LWL/LWR
- req_kill  in  1  younger-than-exception/eret; suppress issue
- flush  in  1  pipeline flush (exception or refill)
- ex_adel, ex_ades  out  1 each  combinational alignment exception for the current request
- data_valid  out  1  cache request
- data_op  out  1  1 = store
- data_tag, data_index, data_offset  out  TAG_W, INDEX_W, OFFSET_W  address split
- data_wstrb  out  4  byte strobe; 0 for loads
- data_wdata  out  32  shifted store data
- data_addr_ok  in  1  cache accepts request
- data_data_ok  in  1  in-order completion
- data_rdata  in  32  load word
- resp_valid  out  1  completion pulse for a live request
- resp_is_store  out  1  completion is a store ack
- resp_rdata  out  32  final register write value

## Operation
- Alignment check: LH/LHU with addr[0]=1 gives AdEL; LW with addr[1:0]≠0 gives AdEL. SH and SW give AdES under the same address rules. LWL/LWR/SWL/SWR never fault.
- Issue: data_valid = req_valid & ~req_kill & ~flush & ~ex_adel & ~ex_ades & (count < MAX_OUTSTANDING).
- req_ready is asserted in two cases:
  - data_valid & data_addr_ok;
  - req_valid & (req_kill | flush | ex_adel | ex_ades). In this case the request is consumed without issue and without a queue entry.
- On accept, push {live=1, type, addr[1:0], req_rt} into the queue.
- Store formatting:
  - SB replicates the byte; wstrb is one-hot on addr[1:0].
  - SH replicates the half; wstrb is 0011 or 1100.
  - SW uses wstrb 1111.
  - SWL: addr 0/1/2/3 gives wstrb 0001/0011/0111/1111, data is rt shifted right by 24/16/8/0.
  - SWR: addr 0/1/2/3 gives wstrb 1111/1110/1100/1000, data is rt shifted left by 0/8/16/24.
- Completion: data_data_ok pops the head entry. If the head is live, the response registers load on the next edge, resp_valid=1 and resp_is_store equals the stored type. If the head is dead, the entry is popped silently.
- Load formatting:
  - LB/LBU/LH/LHU select by addr[1:0] and sign- or zero-extend.
  - LWL merges data_rdata bytes 0..a into the high bytes of rt.
  - LWR merges bytes a..3 into the low bytes of rt (MIPS little-endian).
- Flush clears live on every entry in the same edge. An entry popped in the same cycle as the flush is also suppressed.
- data_data_ok with count = 0 is ignored and the pointers do not move.

## Timing
- Reset: count, pointers and live bits are 0. resp_valid, resp_is_store and resp_rdata are 0. data_valid and req_ready are 0 because they are combinational and gated by count and req_valid.
- Issue is combinational: data_valid and req_ready are valid in the same cycle as req_valid.
- Response latency: resp_valid is 1 cycle after data_data_ok. It is a single-cycle pulse.
- Simultaneous push and pop: count is unchanged and both pointers advance. The earliest data_ok for a request is the cycle after its accept.
- Full (count = MAX_OUTSTANDING): data_valid is 0 and a queued request stalls. The cycle after a pop, issue proceeds.
- Pointers wrap modulo MAX_OUTSTANDING; count is clog2(MAX_OUTSTANDING+1) bits wide.
- Reset mid-operation discards all entries. The cache is reset together with this block.

## Structure
- lsu_pkg holds the req_type encodings, the store strobe/data function, and the load extend/merge function.
- Sub-module lsu_tag_fifo: synchronous circular buffer of depth MAX_OUTSTANDING with push, pop, count and a kill_all port that clears every live bit.

## Test plan
- SB to 0x1003 with rt=0x12345678: data_wstrb=1000, data_wdata=0x78787878; the data_ok returns a store ack with resp_is_store=1.
- LH at 0x2001: ex_adel=1, req_ready=1, data_valid=0, and no queue entry is created.
- Two LW back-to-back with addr_ok=1 and MAX_OUTSTANDING=2: a third LW stalls. Then data_ok, then 0x11111111 and 0x22222222 return as two resp_valid pulses in order.
- LW issued, flush before data_ok: data_ok is consumed, resp_valid stays 0, and count returns to 0.
- LWL at 0x3001, rt=0xAABBCCDD, rdata=0x44332211: resp_rdata=0x2211CCDD. LB at 0x3003 with rdata 0x80xxxxxx gives 0xFFFFFF80.
- Push and pop in the same cycle at count=1: count stays 1 and the pointers wrap correctly across 10 iterations.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, queue entry type and store/load formatting helpers
// for the EXE-stage load/store request controller.
package lsu_pkg;

  typedef enum logic [3:0] {
    LSU_LB  = 4'h0,
    LSU_LBU = 4'h1,
    LSU_LH  = 4'h2,
    LSU_LHU = 4'h3,
    LSU_LW  = 4'h4,
    LSU_LWL = 4'h5,
    LSU_LWR = 4'h6,
    LSU_SB  = 4'h8,
    LSU_SH  = 4'h9,
    LSU_SW  = 4'hA,
    LSU_SWL = 4'hB,
    LSU_SWR = 4'hC
  } lsu_op_e;

  typedef struct packed {
    logic        live;
    logic [3:0]  op;
    logic [1:0]  off;
    logic [31:0] rt;
  } lsu_ent_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_fmt_t;

  function automatic st_fmt_t st_format(
    input logic [3:0]  op,
    input logic [1:0]  a,
    input logic [31:0] rt
  );
    st_fmt_t    f;
    logic [4:0] w_sh;
    logic [4:0] w_shr;
    w_sh  = {a, 3'b000};
    w_shr = {~a, 3'b000};
    f     = '0;
    case (op)
      LSU_SB: begin
        f.wstrb = 4'b0001 << a;
        f.wdata = {4{rt[7:0]}};
      end
      LSU_SH: begin
        f.wstrb = a[1] ? 4'b1100 : 4'b0011;
        f.wdata = {2{rt[15:0]}};
      end
      LSU_SW: begin
        f.wstrb = 4'b1111;
        f.wdata = rt;
      end
      LSU_SWL: begin
        f.wstrb = 4'b1111 >> ~a;
        f.wdata = rt >> w_shr;
      end
      LSU_SWR: begin
        f.wstrb = 4'b1111 << a;
        f.wdata = rt << w_sh;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] ld_format(
    input logic [3:0]  op,
    input logic [1:0]  a,
    input logic [31:0] rt,
    input logic [31:0] rd
  );
    logic [31:0] r;
    logic [31:0] m;
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  w_sh;
    logic [4:0]  w_shr;
    w_sh  = {a, 3'b000};
    w_shr = {~a, 3'b000};
    b     = 8'(rd >> w_sh);
    h     = a[1] ? rd[31:16] : rd[15:0];
    m     = '0;
    case (op)
      LSU_LB:  r = {{24{b[7]}}, b};
      LSU_LBU: r = {24'h0, b};
      LSU_LH:  r = {{16{h[15]}}, h};
      LSU_LHU: r = {16'h0, h};
      // low-address bytes of the word land in the top of rt
      LSU_LWL: begin
        m = 32'hFFFF_FFFF << w_shr;
        r = (rd << w_shr) | (rt & ~m);
      end
      LSU_LWR: begin
        m = 32'hFFFF_FFFF >> w_sh;
        r = (rd >> w_sh) | (rt & ~m);
      end
      default: r = rd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_tag_fifo.sv
// In-order tracking queue for outstanding dcache requests, with a
// kill_all port that turns every queued entry into a silent drop.
module lsu_tag_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  lsu_ent_t      push_data,
  input  logic          pop,
  input  logic          kill_all,
  output lsu_ent_t      head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_ent_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = pop & (r_count != '0);
  assign w_push = push & ((r_count != CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= nxt(r_wr_ptr);
      end
      if (w_pop)
        r_rd_ptr <= nxt(r_rd_ptr);
      if (kill_all)
        for (int i = 0; i < DEPTH; i++)
          r_mem[i].live <= 1'b0;
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (~w_push & w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/lsu_req_ctrl.sv
// Multi-outstanding load/store request controller between EXE and the
// dcache port: alignment checks, store formatting, load extend/merge.
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 20,
  parameter int INDEX_W         = 8,
  parameter int OFFSET_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_type,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_rt,
  input  logic                req_kill,
  input  logic                flush,
  output logic                ex_adel,
  output logic                ex_ades,
  output logic                data_valid,
  output logic                data_op,
  output logic [TAG_W-1:0]    data_tag,
  output logic [INDEX_W-1:0]  data_index,
  output logic [OFFSET_W-1:0] data_offset,
  output logic [3:0]          data_wstrb,
  output logic [31:0]         data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [31:0]         data_rdata,
  output logic                resp_valid,
  output logic                resp_is_store,
  output logic [31:0]         resp_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(MAX_OUTSTANDING);

  logic [1:0]    w_a;
  logic          w_adel;
  logic          w_ades;
  logic          w_drop;
  logic          w_cnt_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_is_st;
  logic          w_resp;
  st_fmt_t       w_st;
  lsu_ent_t      w_ent;
  lsu_ent_t      w_head;
  logic [CW-1:0] w_count;

  logic          r_resp_valid;
  logic          r_resp_is_store;
  logic [31:0]   r_resp_rdata;

  assign w_a     = req_addr[1:0];
  assign w_is_st = req_type[3];

  always_comb begin
    w_adel = 1'b0;
    w_ades = 1'b0;
    unique case (1'b1)
      (req_type == LSU_LH) || (req_type == LSU_LHU):
        w_adel = w_a[0];
      (req_type == LSU_LW):
        w_adel = |w_a;
      (req_type == LSU_SH):
        w_ades = w_a[0];
      (req_type == LSU_SW):
        w_ades = |w_a;
      default: ;
    endcase
  end

  assign ex_adel  = req_valid & w_adel;
  assign ex_ades  = req_valid & w_ades;
  assign w_drop   = req_kill | flush | ex_adel | ex_ades;
  assign w_cnt_ok = w_count < LP_MAX;

  assign data_valid = req_valid & ~w_drop & w_cnt_ok;
  assign w_push     = data_valid & data_addr_ok;
  // faulting or killed requests are consumed without reaching the cache
  assign req_ready  = w_push | (req_valid & w_drop);
  assign w_pop      = data_data_ok & (w_count != '0);

  assign w_st        = st_format(req_type, w_a, req_rt);
  assign data_op     = w_is_st;
  assign data_wstrb  = w_is_st ? w_st.wstrb : 4'b0000;
  assign data_wdata  = w_is_st ? w_st.wdata : 32'h0;
  assign data_tag    = req_addr[31 -: TAG_W];
  assign data_index  = req_addr[OFFSET_W +: INDEX_W];
  assign data_offset = req_addr[OFFSET_W-1:0];

  assign w_ent.live = 1'b1;
  assign w_ent.op   = req_type;
  assign w_ent.off  = w_a;
  assign w_ent.rt   = req_rt;

  lsu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_ent),
    .pop       (w_pop),
    .kill_all  (flush),
    .head      (w_head),
    .count     (w_count)
  );

  assign w_resp = w_pop & w_head.live & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid    <= 1'b0;
      r_resp_is_store <= 1'b0;
      r_resp_rdata    <= '0;
    end else begin
      r_resp_valid <= w_resp;
      if (w_resp) begin
        r_resp_is_store <= w_head.op[3];
        r_resp_rdata    <= w_head.op[3] ? 32'h0 :
          ld_format(w_head.op, w_head.off, w_head.rt, data_rdata);
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_is_store = r_resp_is_store;
  assign resp_rdata    = r_resp_rdata;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed bench for lsu_req_ctrl with hand-computed expectations.
module tb_lsu_req_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_rt;
  logic        req_kill;
  logic        flush;
  logic        ex_adel;
  logic        ex_ades;
  logic        data_valid;
  logic        data_op;
  logic [19:0] data_tag;
  logic [7:0]  data_index;
  logic [3:0]  data_offset;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        resp_valid;
  logic        resp_is_store;
  logic [31:0] resp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_req_ctrl #(
    .MAX_OUTSTANDING (2),
    .TAG_W           (20),
    .INDEX_W         (8),
    .OFFSET_W        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_rt        (req_rt),
    .req_kill      (req_kill),
    .flush         (flush),
    .ex_adel       (ex_adel),
    .ex_ades       (ex_ades),
    .data_valid    (data_valid),
    .data_op       (data_op),
    .data_tag      (data_tag),
    .data_index    (data_index),
    .data_offset   (data_offset),
    .data_wstrb    (data_wstrb),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .resp_valid    (resp_valid),
    .resp_is_store (resp_is_store),
    .resp_rdata    (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid    = 1'b0;
    req_kill     = 1'b0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] rt);
    req_valid    = 1'b1;
    req_type     = t;
    req_addr     = a;
    req_rt       = rt;
    data_addr_ok = 1'b1;
  endtask

  task automatic do_load(input string tag, input logic [3:0] t,
                         input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(t, a, rt);
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    tick();
    idle();
    data_data_ok = 1'b1;
    data_rdata   = rd;
    tick();
    idle();
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_st"}, 32'(resp_is_store), 32'd0);
    chk(tag, resp_rdata, exp);
  endtask

  task automatic do_store(input string tag, input logic [3:0] t,
                          input logic [31:0] a, input logic [31:0] rt,
                          input logic [3:0] strb, input logic [31:0] wd);
    issue(t, a, rt);
    #1;
    chk({tag, "_strb"}, 32'(data_wstrb), 32'(strb));
    chk({tag, "_wdata"}, data_wdata, wd);
    chk({tag, "_op"}, 32'(data_op), 32'd1);
    tick();
    idle();
    data_data_ok = 1'b1;
    tick();
    idle();
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_st"}, 32'(resp_is_store), 32'd1);
  endtask

  initial begin
    idle();
    req_type = 4'h0;
    req_addr = 32'h0;
    req_rt   = 32'h0;
    reset    = 1'b1;
    tick();
    tick();
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_rs", 32'(resp_is_store), 32'd0);
    chk("rst_rd", resp_rdata, 32'h0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_cnt", 32'(dut.u_fifo.r_count), 32'd0);
    reset = 1'b0;

    issue(LSU_SB, 32'h0000_1003, 32'h1234_5678);
    #1;
    chk("sb_dv", 32'(data_valid), 32'd1);
    chk("sb_tag", 32'(data_tag), 32'h1);
    chk("sb_idx", 32'(data_index), 32'h0);
    chk("sb_off", 32'(data_offset), 32'h3);
    idle();
    do_store("sb", LSU_SB, 32'h0000_1003, 32'h1234_5678, 4'b1000, 32'h7878_7878);
    tick();
    chk("sb_pulse", 32'(resp_valid), 32'd0);

    do_store("sh", LSU_SH, 32'h0000_3002, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    do_store("swl", LSU_SWL, 32'h0000_3001, 32'h1234_5678, 4'b0011, 32'h0000_1234);
    do_store("swr", LSU_SWR, 32'h0000_3002, 32'h1234_5678, 4'b1100, 32'h5678_0000);

    issue(LSU_LH, 32'h0000_2001, 32'h0);
    #1;
    chk("adel", 32'(ex_adel), 32'd1);
    chk("adel_es", 32'(ex_ades), 32'd0);
    chk("adel_rdy", 32'(req_ready), 32'd1);
    chk("adel_dv", 32'(data_valid), 32'd0);
    tick();
    chk("adel_cnt", 32'(dut.u_fifo.r_count), 32'd0);
    issue(LSU_SW, 32'h0000_2002, 32'h0);
    #1;
    chk("ades", 32'(ex_ades), 32'd1);
    chk("ades_dv", 32'(data_valid), 32'd0);
    issue(LSU_LWL, 32'h0000_2003, 32'h0);
    #1;
    chk("lwl_noexc", 32'(ex_adel), 32'd0);
    req_type = LSU_LW;
    req_kill = 1'b1;
    #1;
    chk("kill_dv", 32'(data_valid), 32'd0);
    chk("kill_rdy", 32'(req_ready), 32'd1);
    idle();
    tick();
    chk("kill_cnt", 32'(dut.u_fifo.r_count), 32'd0);

    issue(LSU_LW, 32'h0000_0100, 32'h0);
    #1;
    chk("lw1_dv", 32'(data_valid), 32'd1);
    tick();
    req_addr = 32'h0000_0104;
    tick();
    chk("lw2_cnt", 32'(dut.u_fifo.r_count), 32'd2);
    req_addr = 32'h0000_0108;
    #1;
    chk("full_dv", 32'(data_valid), 32'd0);
    chk("full_rdy", 32'(req_ready), 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_1111;
    tick();
    chk("lw1_vld", 32'(resp_valid), 32'd1);
    chk("lw1_rd", resp_rdata, 32'h1111_1111);
    chk("pop_cnt", 32'(dut.u_fifo.r_count), 32'd1);
    chk("resume_dv", 32'(data_valid), 32'd1);
    data_rdata = 32'h2222_2222;
    tick();
    chk("lw2_vld", 32'(resp_valid), 32'd1);
    chk("lw2_rd", resp_rdata, 32'h2222_2222);
    chk("pp_cnt", 32'(dut.u_fifo.r_count), 32'd1);
    req_valid    = 1'b0;
    data_addr_ok = 1'b0;
    data_rdata   = 32'h3333_3333;
    tick();
    chk("lw3_rd", resp_rdata, 32'h3333_3333);
    chk("drain_cnt", 32'(dut.u_fifo.r_count), 32'd0);
    idle();
    tick();
    chk("drain_rv", 32'(resp_valid), 32'd0);

    issue(LSU_LW, 32'h0000_0200, 32'h0);
    tick();
    idle();
    flush = 1'b1;
    tick();
    idle();
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("flush_rv", 32'(resp_valid), 32'd0);
    chk("flush_cnt", 32'(dut.u_fifo.r_count), 32'd0);
    issue(LSU_LW, 32'h0000_0204, 32'h0);
    tick();
    idle();
    flush        = 1'b1;
    data_data_ok = 1'b1;
    tick();
    idle();
    chk("fpop_rv", 32'(resp_valid), 32'd0);
    chk("fpop_cnt", 32'(dut.u_fifo.r_count), 32'd0);
    data_data_ok = 1'b1;
    tick();
    idle();
    chk("empty_rv", 32'(resp_valid), 32'd0);
    chk("empty_cnt", 32'(dut.u_fifo.r_count), 32'd0);

    do_load("lwl", LSU_LWL, 32'h0000_3001, 32'hAABB_CCDD, 32'h4433_2211, 32'h2211_CCDD);
    do_load("lwr", LSU_LWR, 32'h0000_3002, 32'hAABB_CCDD, 32'h4433_2211, 32'hAABB_4433);
    do_load("lb", LSU_LB, 32'h0000_3003, 32'h0, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu", LSU_LBU, 32'h0000_3003, 32'h0, 32'h8012_3456, 32'h0000_0080);
    do_load("lhu", LSU_LHU, 32'h0000_3002, 32'h0, 32'h8001_1234, 32'h0000_8001);
    do_load("lh", LSU_LH, 32'h0000_3000, 32'h0, 32'h0000_F00F, 32'hFFFF_F00F);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(LSU_LW, 32'h0000_0400, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      req_addr     = 32'h0000_0404 + 32'(4 * i);
      data_data_ok = 1'b1;
      data_rdata   = 32'hA000_0000 + 32'(i);
      tick();
      chk("pp_vld", 32'(resp_valid), 32'd1);
      chk("pp_rd", resp_rdata, 32'hA000_0000 + 32'(i));
      chk("pp_cnt1", 32'(dut.u_fifo.r_count), 32'd1);
      chk("pp_wr", 32'(dut.u_fifo.r_wr_ptr), 32'((i + 2) % 2));
      chk("pp_rdp", 32'(dut.u_fifo.r_rd_ptr), 32'((i + 1) % 2));
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
